// File: rtl/sram_responder.sv
// sram_responder: single-cycle SRAM target with byte strobes, range checking and LFSR-driven stall insertion
module sram_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter bit          STALL_EN    = 1'b1,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        mem_cen,
   input  logic        mem_wen,
   input  logic [3:0]  mem_strb,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_stall,
   output logic        mem_error,
   output logic [31:0] mem_rdata,
   output logic        proto_err
);
   localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
   localparam logic [15:0] SEED = LFSR_SEED == 16'h0000 ? 16'h0001 : LFSR_SEED;
   localparam logic [0:0] IDLE = 1'b0, HOLD = 1'b1;
   logic [0:0]    state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          error_q, error_d, proto_q, proto_d, accept, in_range;
   logic [32:0]   diff;
   logic [AW-1:0] idx;
   logic [31:0]   mem_q [DEPTH_WORDS];
   // a 33-bit difference makes addresses below the base wrap far above LIMIT
   always_comb begin
      diff      = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
      in_range  = diff < LIMIT;
      idx       = diff[AW+1:2];
      mem_stall = !g_reset && mem_cen &&
                  (state_q == IDLE ? STALL_EN && lfsr_q[1:0] != 2'd0 : cnt_q != 2'd0);
      accept    = !g_reset && mem_cen && !mem_stall;
      lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      state_d   = mem_stall ? HOLD : IDLE;
      cnt_d     = !mem_stall ? cnt_q : state_q == IDLE ? lfsr_q[1:0] - 2'd1 : cnt_q - 2'd1;
      proto_d   = proto_q || (state_q == HOLD && !mem_cen);
      error_d   = accept && !in_range;
      rdata_d   = accept && !mem_wen ? (in_range ? mem_q[idx] : 32'd0) : rdata_q;
   end
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         lfsr_q  <= SEED;
         rdata_q <= 32'd0;
         error_q <= 1'b0;
         proto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
         proto_q <= proto_d;
      end
   end
   // backing store is intentionally not reset
   always_ff @(posedge g_clk) begin
      if (accept && mem_wen && in_range)
         for (int b = 0; b < 4; b++)
            if (mem_strb[b]) mem_q[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
   end
   assign mem_error = error_q;
   assign mem_rdata = rdata_q;
   assign proto_err = proto_q;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed and random checks of two responders (stall-free and stalling) against an array model
module tb_sram_responder;
   localparam logic [31:0] B1    = 32'h0001_0000;
   localparam logic [15:0] SEED1 = 16'hACE3;
   logic        clk = 1'b0, rst = 1'b1, cen0 = 1'b0, cen1 = 1'b0, wen = 1'b0;
   logic [3:0]  strb = 4'h0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic        stall0, err0, proto0, stall1, err1, proto1;
   logic [31:0] rd0, rd1;
   logic [31:0] mem0 [1024];
   logic [31:0] mem1 [256];
   logic [31:0] exp_rd0 = 32'd0, exp_rd1 = 32'd0;
   logic        exp_proto1 = 1'b0;
   logic [15:0] m_lfsr = SEED1;
   int tests = 0, fails = 0;

   sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .STALL_EN(1'b0), .LFSR_SEED(16'hACE1)) u0 (
      .g_clk(clk), .g_reset(rst), .mem_cen(cen0), .mem_wen(wen), .mem_strb(strb), .mem_addr(addr),
      .mem_wdata(wdata), .mem_stall(stall0), .mem_error(err0), .mem_rdata(rd0), .proto_err(proto0));
   sram_responder #(.DEPTH_WORDS(256), .BASE_ADDR(B1), .STALL_EN(1'b1), .LFSR_SEED(SEED1)) u1 (
      .g_clk(clk), .g_reset(rst), .mem_cen(cen1), .mem_wen(wen), .mem_strb(strb), .mem_addr(addr),
      .mem_wdata(wdata), .mem_stall(stall1), .mem_error(err1), .mem_rdata(rd1), .proto_err(proto1));

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], ^(v & 16'hB400)};
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] m;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (n & m) | (o & ~m);
   endfunction

   always #5 clk = ~clk;
   always @(posedge clk) m_lfsr <= rst ? SEED1 : lfsr_next(m_lfsr);

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic check_b(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic req0(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
      logic inr;
      cen1 = 1'b0; cen0 = 1'b1; wen = w; strb = s; addr = a; wdata = d;
      #1 check_b("stall0", stall0, 1'b0);
      @(posedge clk); #1;
      inr = a < 32'h1000;
      if (inr && w) mem0[a[11:2]] = merge(mem0[a[11:2]], d, s);
      if (!w) exp_rd0 = inr ? mem0[a[11:2]] : 32'd0;
      check("rdata0", rd0, exp_rd0);
      check_b("error0", err0, !inr);
   endtask

   task automatic req1(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
      logic inr;
      logic [31:0] off;
      int n;
      cen0 = 1'b0; cen1 = 1'b1; wen = w; strb = s; addr = a; wdata = d;
      #1 n = int'(m_lfsr[1:0]);
      repeat (n) begin
         check_b("stall1_on", stall1, 1'b1);
         @(posedge clk); #1;
      end
      check_b("stall1_off", stall1, 1'b0);
      @(posedge clk); #1;
      off = a - B1;
      inr = a >= B1 && off < 32'd1024;
      if (inr && w) mem1[off[9:2]] = merge(mem1[off[9:2]], d, s);
      if (!w) exp_rd1 = inr ? mem1[off[9:2]] : 32'd0;
      check("rdata1", rd1, exp_rd1);
      check_b("error1", err1, !inr);
      check_b("proto1", proto1, exp_proto1);
   endtask

   task automatic idle(input int n);
      cen0 = 1'b0; cen1 = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
         check_b("idle_stall0", stall0, 1'b0);
         check_b("idle_stall1", stall1, 1'b0);
         check_b("idle_err0", err0, 1'b0);
         check_b("idle_err1", err1, 1'b0);
         check("idle_rd0", rd0, exp_rd0);
         check("idle_rd1", rd1, exp_rd1);
         check_b("idle_proto0", proto0, 1'b0);
         check_b("idle_proto1", proto1, exp_proto1);
      end
   endtask

   task automatic rst_pulse();
      cen0 = 1'b0; cen1 = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      exp_rd0 = 32'd0; exp_rd1 = 32'd0; exp_proto1 = 1'b0;
      check("rst_rd0", rd0, 32'd0);
      check("rst_rd1", rd1, 32'd0);
      check_b("rst_err1", err1, 1'b0);
      check_b("rst_proto1", proto1, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      cen1 = 1'b1; wen = 1'b0; addr = B1;
      repeat (3) @(posedge clk);
      #1;
      check_b("reset_stall1", stall1, 1'b0);
      check_b("reset_stall0", stall0, 1'b0);
      check("reset_rd0", rd0, 32'd0);
      check("reset_rd1", rd1, 32'd0);
      check_b("reset_err0", err0, 1'b0);
      check_b("reset_err1", err1, 1'b0);
      check_b("reset_proto1", proto1, 1'b0);
      rst = 1'b0;
      // first request after reset sees the seed, so it takes three stalls
      for (int i = 0; i < 256; i++) req1(1'b1, 4'hF, B1 + 32'(i * 4), $urandom);
      for (int i = 0; i < 1024; i++) req0(1'b1, 4'hF, 32'(i * 4), $urandom);
      idle(2);
      req0(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      req0(1'b0, 4'hF, 32'h10, 32'h0);
      check("req_full_word", rd0, 32'hDEADBEEF);
      req0(1'b1, 4'h1, 32'h10, 32'h0000_00AA);
      req0(1'b0, 4'hF, 32'h10, 32'h0);
      check("req_byte_strobe", rd0, 32'hDEADBEAA);
      req0(1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF);
      req0(1'b0, 4'hF, 32'h13, 32'h0);
      check("req_zero_strobe", rd0, 32'hDEADBEAA);
      req0(1'b0, 4'hF, 32'h1000, 32'h0);
      check("oor_read_rdata", rd0, 32'd0);
      idle(1);
      req0(1'b1, 4'hF, 32'h1000, $urandom);
      req0(1'b1, 4'hF, 32'hFFFF_FFFC, $urandom);
      for (int i = 0; i < 1024; i++) req0(1'b0, 4'hF, 32'(i * 4), 32'h0);
      for (int i = 0; i < 200; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? $urandom : {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom)};
         req0(1'($urandom), 4'($urandom), a, $urandom);
      end
      idle(2);
      for (int i = 0; i < 300; i++)
         req1(1'($urandom), 4'($urandom), B1 - 32'h100 + 32'($urandom_range(0, 32'h600)), $urandom);
      idle(2);
      rst_pulse();
      req1(1'b0, 4'hF, B1 + 32'h20, 32'h0);
      check("stall3_read", rd1, mem1[8]);
      // initiator abandons a stalled write in its second stall cycle
      rst_pulse();
      cen1 = 1'b1; wen = 1'b1; strb = 4'hF; addr = B1 + 32'h40; wdata = ~mem1[16];
      #1 check_b("drop_stall_c1", stall1, 1'b1);
      @(posedge clk); #1;
      check_b("drop_stall_c2", stall1, 1'b1);
      cen1 = 1'b0;
      #1 check_b("drop_stall_off", stall1, 1'b0);
      @(posedge clk); #1;
      check_b("drop_proto_set", proto1, 1'b1);
      exp_proto1 = 1'b1;
      idle(3);
      req1(1'b0, 4'hF, B1 + 32'h40, 32'h0);
      check("drop_store_kept", rd1, mem1[16]);
      rst_pulse();
      cen1 = 1'b1; wen = 1'b1; strb = 4'hF; addr = B1 + 32'h80; wdata = ~mem1[32];
      #1 check_b("hold_rst_stall", stall1, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1 check_b("hold_rst_gated", stall1, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; cen1 = 1'b0; exp_rd1 = 32'd0;
      check_b("hold_rst_proto", proto1, 1'b0);
      check("hold_rst_rd1", rd1, 32'd0);
      req1(1'b0, 4'hF, B1 + 32'h80, 32'h0);
      check("hold_rst_store", rd1, mem1[32]);
      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the backing store; power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; DEPTH_WORDS-aligned.
REQ-003 Parameter STALL_EN, default 1: 1 = pseudo-random stall insertion; 0 = never stall.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: stall LFSR reset value; 16'h0000 is replaced by 16'h0001.
REQ-005 g_clk  input  1  global clock; all state updates on the rising edge.
REQ-006 g_reset  input  1  synchronous reset, active-high.
REQ-007 mem_cen  input  1  chip enable; request present.
REQ-008 mem_wen  input  1  1 = write, 0 = read.
REQ-009 mem_strb  input  4  write byte strobes; bit n selects wdata[8n+7:8n].
REQ-010 mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-011 mem_wdata  input  32  write data.
REQ-012 mem_stall  output  1  request not accepted this cycle; initiator holds request stable.
REQ-013 mem_error  output  1  one-cycle error response for the previously accepted request.
REQ-014 mem_rdata  output  32  read data for the previously accepted read.
REQ-015 proto_err  output  1  sticky flag: initiator dropped mem_cen while stalled.

Function
REQ-016 A request is accepted in a cycle with mem_cen=1, mem_stall=0 and g_reset=0.
REQ-017 In range: BASE_ADDR <= mem_addr < BASE_ADDR+4*DEPTH_WORDS; word index = (mem_addr-BASE_ADDR)>>2.
REQ-018 Stall LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every non-reset cycle regardless of traffic.
REQ-019 FSM states IDLE and HOLD; 2-bit stall counter cnt.
REQ-020 IDLE, mem_cen=0: mem_stall=0, stay IDLE.
REQ-021 IDLE, mem_cen=1, STALL_EN=0 or lfsr[1:0]=0: mem_stall=0, request accepted, stay IDLE.
REQ-022 IDLE, mem_cen=1, STALL_EN=1, lfsr[1:0]!=0: mem_stall=1, cnt<=lfsr[1:0]-1, go HOLD; total stall = lfsr[1:0] cycles (1..3).
REQ-023 HOLD, mem_cen=1: mem_stall=(cnt!=0); cnt!=0: cnt<=cnt-1, stay HOLD; cnt=0: request accepted, go IDLE.
REQ-024 HOLD, mem_cen=0: mem_stall=0, no access, proto_err<=1, go IDLE.
REQ-025 mem_stall is combinational from state, cnt, lfsr and mem_cen; it is 0 whenever mem_cen=0.
REQ-026 Accepted in-range write: every byte with strb bit set is written at that edge; strb=4'b0000 changes nothing and is not an error.
REQ-027 Accepted in-range read: mem_rdata = stored word exactly one cycle later.
REQ-028 Accepted out-of-range request: no store change; mem_error=1 for the next cycle only; a read returns mem_rdata=0.
REQ-029 mem_error=0 in every cycle not immediately following an accepted out-of-range request.
REQ-030 mem_rdata holds its last value until the next accepted read; accepted writes do not change it.
REQ-031 Back-to-back write then read of the same word returns the newly written bytes.
REQ-032 Back-to-back accepted requests with no idle cycle are supported at one per cycle when unstalled.
REQ-033 Read latency: 1 cycle after acceptance; write completes at the acceptance edge.

Reset
REQ-034 During g_reset=1: state=IDLE, cnt=0, lfsr=LFSR_SEED, mem_rdata=0, mem_error=0, proto_err=0, mem_stall=0; no request accepted.
REQ-035 Reset asserted mid-stall aborts the request without a store write and without setting proto_err.
REQ-036 Backing-store contents are not reset.

Verification
REQ-037 STALL_EN=0; write 0xDEADBEEF to 0x10 with strb=1111, then read 0x10 -> mem_stall always 0, rdata=0xDEADBEEF one cycle after read acceptance.
REQ-038 Word 0x10=0xDEADBEEF; write 0x000000AA, strb=0001, then read -> rdata=0xDEADBEAA.
REQ-039 DEPTH_WORDS=1024, BASE_ADDR=0; read 0x1000 -> mem_error=1 for exactly one cycle, rdata=0; write 0x1000 leaves words 0..1023 unchanged.
REQ-040 STALL_EN=1, LFSR_SEED chosen so lfsr[1:0]=3 at request start -> mem_stall=1 for exactly 3 cycles, acceptance on 4th, rdata valid on 5th.
REQ-041 Drop mem_cen in second stall cycle -> mem_stall=0 next cycle, proto_err=1 and stays 1 until g_reset, store unchanged.
REQ-042 Assert g_reset during HOLD of a stalled write -> FSM in IDLE after reset, proto_err=0, target word unchanged.
